// File: rtl/spram_ctrl_pkg.sv
// rtl/spram_ctrl_pkg.sv - shared widths and FSM state type for the SPRAM arbiter
package spram_ctrl_pkg;

  localparam int SPRAM_ADDR_W = 14;
  localparam int SPRAM_DATA_W = 16;
  localparam int SPRAM_MASK_W = 4;

  typedef enum logic [1:0] {
    ST_ACTIVE  = 2'd0,
    ST_STANDBY = 2'd1,
    ST_WAKE    = 2'd2
  } spram_state_t;

endpackage

// File: rtl/spram_rr_arb2.sv
// rtl/spram_rr_arb2.sv - two-request round-robin arbiter with registered last-grant pointer
module spram_rr_arb2
  import spram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  // 1 = port 1 won the most recent grant; reset value makes port 0 win the first conflict
  logic last_p1;

  // One-hot grant: a lone requester wins, a conflict goes to the port not granted last
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_p1 ? 2'b01 : 2'b10;
    end
  end

  // Remember who was served whenever a grant is actually taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_p1 <= 1'b1;
    end else if (update) begin
      last_p1 <= gnt[1];
    end
  end

endmodule

// File: rtl/spram_arbiter.sv
// rtl/spram_arbiter.sv - two-port SB_SPRAM256KA controller; optional standby via SPRAM_ARB_STANDBY_EN
module spram_arbiter
  import spram_ctrl_pkg::*;
#(
  parameter int IDLE_CYCLES = 64,
  parameter int WAKE_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    p0_valid_i,
  output logic                    p0_ready_o,
  input  logic                    p0_we_i,
  input  logic [SPRAM_ADDR_W-1:0] p0_addr_i,
  input  logic [SPRAM_DATA_W-1:0] p0_wdata_i,
  input  logic [SPRAM_MASK_W-1:0] p0_mask_i,
  output logic                    p0_rsp_valid_o,
  input  logic                    p1_valid_i,
  output logic                    p1_ready_o,
  input  logic                    p1_we_i,
  input  logic [SPRAM_ADDR_W-1:0] p1_addr_i,
  input  logic [SPRAM_DATA_W-1:0] p1_wdata_i,
  input  logic [SPRAM_MASK_W-1:0] p1_mask_i,
  output logic                    p1_rsp_valid_o,
  output logic [SPRAM_DATA_W-1:0] rsp_rdata_o,
  output logic [SPRAM_ADDR_W-1:0] ram_addr_o,
  output logic [SPRAM_DATA_W-1:0] ram_din_o,
  output logic [SPRAM_MASK_W-1:0] ram_mask_o,
  output logic                    ram_wren_o,
  output logic                    ram_cs_o,
  output logic                    ram_standby_o,
  output logic                    ram_sleep_o,
  output logic                    ram_poweroff_o,
  input  logic [SPRAM_DATA_W-1:0] ram_dout_i
);

  logic [1:0]              req;
  logic [1:0]              gnt;
  logic [1:0]              ready;
  logic                    accept;
  logic                    grant_en;
  spram_state_t            state;
  logic [SPRAM_ADDR_W-1:0] addr_q;
  logic [SPRAM_DATA_W-1:0] din_q;
  logic [SPRAM_ADDR_W-1:0] sel_addr;
  logic [SPRAM_DATA_W-1:0] sel_din;
  logic [SPRAM_MASK_W-1:0] sel_mask;
  logic                    sel_we;
  logic [1:0]              rsp_q;

  assign req = {p1_valid_i, p0_valid_i};

  // Grants only flow in ACTIVE and never while reset is held
  assign grant_en = rst_n && (state == ST_ACTIVE);
  assign ready    = gnt & {2{grant_en}};
  assign accept   = |ready;

  assign p0_ready_o = ready[0];
  assign p1_ready_o = ready[1];

  spram_rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .update (accept),
    .gnt    (gnt)
  );

  // Payload of the granted port
  always_comb begin
    sel_addr = p0_addr_i;
    sel_din  = p0_wdata_i;
    sel_mask = p0_mask_i;
    sel_we   = p0_we_i;
    if (ready[1]) begin
      sel_addr = p1_addr_i;
      sel_din  = p1_wdata_i;
      sel_mask = p1_mask_i;
      sel_we   = p1_we_i;
    end
  end

  // The macro samples its pins on the same edge that completes the handshake
  assign ram_cs_o   = accept;
  assign ram_wren_o = accept && sel_we;
  assign ram_mask_o = accept ? sel_mask : '0;
  assign ram_addr_o = accept ? sel_addr : addr_q;
  assign ram_din_o  = accept ? sel_din  : din_q;

  // Hold address and data lines steady between transactions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      din_q  <= '0;
    end else if (accept) begin
      addr_q <= sel_addr;
      din_q  <= sel_din;
    end
  end

  // Flag which port owns the data the macro presents on the next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q <= 2'b00;
    end else begin
      rsp_q[0] <= ready[0] && !p0_we_i;
      rsp_q[1] <= ready[1] && !p1_we_i;
    end
  end

  assign p0_rsp_valid_o = rsp_q[0];
  assign p1_rsp_valid_o = rsp_q[1];
  assign rsp_rdata_o    = ram_dout_i;

  assign ram_sleep_o    = 1'b0;
  assign ram_poweroff_o = 1'b1;

`ifdef SPRAM_ARB_STANDBY_EN
  localparam logic [15:0] IDLE_LIM = 16'(IDLE_CYCLES);
  localparam logic [3:0]  WAKE_LIM = 4'(WAKE_CYCLES);

  logic [15:0] idle_cnt;
  logic [3:0]  wake_cnt;
  logic        standby_q;

  // Power FSM: count idle ACTIVE cycles, park in standby, wake on any request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_ACTIVE;
      idle_cnt  <= '0;
      wake_cnt  <= '0;
      standby_q <= 1'b0;
    end else begin
      case (state)
        ST_ACTIVE: begin
          if (|req) begin
            idle_cnt <= '0;
          end else if (idle_cnt != IDLE_LIM) begin
            idle_cnt <= idle_cnt + 16'd1;
            if (idle_cnt + 16'd1 == IDLE_LIM) begin
              state     <= ST_STANDBY;
              standby_q <= 1'b1;
            end
          end
        end
        ST_STANDBY: begin
          if (|req) begin
            state     <= ST_WAKE;
            wake_cnt  <= '0;
            standby_q <= 1'b0;
          end
        end
        ST_WAKE: begin
          if (wake_cnt == WAKE_LIM - 4'd1) begin
            state    <= ST_ACTIVE;
            idle_cnt <= '0;
          end else begin
            wake_cnt <= wake_cnt + 4'd1;
          end
        end
        default: begin
          state     <= ST_ACTIVE;
          standby_q <= 1'b0;
        end
      endcase
    end
  end

  assign ram_standby_o = standby_q;
`else
  logic unused_cfg;

  assign state         = ST_ACTIVE;
  assign ram_standby_o = 1'b0;
  assign unused_cfg    = (IDLE_CYCLES == WAKE_CYCLES);
`endif

endmodule

// File: doc/spram_arbiter.md
# spram_arbiter

Two-port controller for a single 16K×16 iCE40UP single-port RAM macro (SB_SPRAM256KA). It shares the macro between two requesters through valid/ready request channels and drives the macro's pins directly. It returns read data with fixed one-cycle latency. When compiled in, it places the macro in standby after a programmable idle period and wakes it transparently on the next request.

## Interface
Parameters:
- IDLE_CYCLES, 64: consecutive request-free ACTIVE cycles before entering standby (1..65535).
- WAKE_CYCLES, 2: cycles with standby deasserted before requests are accepted again (1..15).

Ports:
- clk  input  1  system clock; also drives the RAM CLOCK pin.
- rst_n  input  1  asynchronous, active-low reset.
- pN_valid_i (N=0,1)  input  1  request valid.
- pN_ready_o  output  1  request accepted this cycle.
- pN_we_i  input  1  1 = write, 0 = read.
- pN_addr_i  input  14  word address.
- pN_wdata_i  input  16  write data.
- pN_mask_i  input  4  nibble write enables; bit k covers bits [4k+3:4k].
- pN_rsp_valid_o  output  1  read data valid for port N.
- rsp_rdata_o  output  16  read data, shared by both ports; qualified by pN_rsp_valid_o.
- ram_addr_o  output  14  to ADDRESS.
- ram_din_o  output  16  to DATAIN.
- ram_mask_o  output  4  to MASKWREN.
- ram_wren_o  output  1  to WREN.
- ram_cs_o  output  1  to CHIPSELECT.
- ram_standby_o  output  1  to STANDBY.
- ram_sleep_o  output  1  to SLEEP; tied 0.
- ram_poweroff_o  output  1  to POWEROFF; tied 1, so the array is always retained.
- ram_dout_i  input  16  from DATAOUT.

## Operation
- FSM states: ACTIVE, STANDBY, WAKE. Reset state is ACTIVE.
- ACTIVE
  - Requests are arbitrated combinationally and handed over at the rising clock edge.
  - One valid port: that port is granted.
  - Both ports valid: round-robin. The port not granted last is granted. The last-grant pointer resets to port 1, so port 0 wins the first conflict.
  - Granted port: pN_ready_o=1. Its addr, wdata and mask drive the ram_* outputs. ram_wren_o=pN_we_i and ram_cs_o=1.
  - No grant: ram_cs_o=0, ram_wren_o=0, ram_mask_o=0. ram_addr_o and ram_din_o hold the last values driven.
- Handshake
  - A requester holds valid and its payload stable until ready is seen.
  - The controller never deasserts ready to a valid port in the same cycle without granting the other port.
- Reads: pN_rsp_valid_o pulses for exactly one cycle, one cycle after acceptance. rsp_rdata_o = ram_dout_i, passed through combinationally.
- Writes
  - No response is returned. Any nibble with a 0 mask bit keeps its RAM contents.
  - A write with mask 0 still counts as an accepted transaction.
- Idle counter
  - Cleared by any valid on either port.
  - Increments on each ACTIVE cycle with no valid, saturating at IDLE_CYCLES.
  - When it reaches IDLE_CYCLES the FSM goes to STANDBY.
- STANDBY: ram_standby_o=1, ram_cs_o=0, both ready outputs 0. Any valid moves the FSM to WAKE on the next edge.
- WAKE: ram_standby_o=0 and ready outputs stay 0 for WAKE_CYCLES cycles, then the FSM returns to ACTIVE with the counter cleared.
- Reset asserted mid-operation: a pending pN_rsp_valid_o is dropped and the FSM returns to ACTIVE. RAM contents are not touched.

## Timing
- Reset values:
  - all ready outputs 0 while rst_n=0
  - pN_rsp_valid_o=0
  - ram_cs_o=0, ram_wren_o=0, ram_mask_o=0
  - ram_addr_o=0, ram_din_o=0
  - ram_standby_o=0
- Read latency is 1 cycle from acceptance to response.
- Back-to-back accepted reads give back-to-back responses. A read immediately followed by a write is legal; the read response is unaffected.
- Throughput is one transaction per cycle while ACTIVE.
- Wake penalty: a request arriving in STANDBY is accepted WAKE_CYCLES+1 cycles after valid first rises.
- pN_ready_o depends combinationally on valid inputs and state only, never on ram_dout_i.

## Configuration
- SPRAM_ARB_STANDBY_EN defined: idle counter and the STANDBY and WAKE states are implemented as described.
- Undefined: the FSM stays permanently in ACTIVE, ram_standby_o is tied 0, the idle counter is removed, and IDLE_CYCLES and WAKE_CYCLES are ignored.

## Structure
- Package spram_ctrl_pkg holds:
  - SPRAM_ADDR_W=14, SPRAM_DATA_W=16, SPRAM_MASK_W=4
  - the state enum: ST_ACTIVE, ST_STANDBY, ST_WAKE
- Sub-module spram_rr_arb2: two-request round-robin arbiter with registered last-grant pointer. Outputs a one-hot grant and takes an update strobe.
- The top level holds the FSM, the idle and wake counters, the pin mux and the response registers.

## Test plan
- Reset: rst_n low with both valids high → both ready 0, ram_cs_o=0, ram_standby_o=0, rsp valids 0. Release → port 0 is granted first.
- Write then read: port 0 writes addr 0x0123 data 0xBEEF mask 0xF, then reads 0x0123 → p0_rsp_valid_o high one cycle later with rsp_rdata_o=0xBEEF.
- Nibble mask: after the previous step, port 1 writes addr 0x0123 data 0x1234 mask 0x5, then reads 0x0123 → 0xB2E4.
- Contention: both ports issue reads continuously for 6 cycles → grants alternate 0,1,0,1,0,1. Each response goes only to its own rsp_valid and arrives 1 cycle after acceptance.
- Standby (macro defined, IDLE_CYCLES=4, WAKE_CYCLES=2): 4 idle cycles → ram_standby_o=1. Port 1 then reads 0x3FFF → standby drops the next cycle and ready rises 3 cycles after valid. The read returns the stored value.
- Macro undefined: 1000 idle cycles → ram_standby_o stays 0, and the first request is accepted in the same cycle it is asserted.
